// File: rtl/lif_pkg.sv
// Shared constants for the leaky integrate-and-fire node: config register
// addresses and the post-spike reset modes.
package lif_pkg;

  localparam logic [1:0] CFG_THRESH = 2'd0;
  localparam logic [1:0] CFG_REFRAC = 2'd1;
  localparam logic [1:0] CFG_MODE   = 2'd2;
  localparam logic [1:0] CFG_CLRSAT = 2'd3;

  typedef enum logic {
    RESET_ZERO = 1'b0,
    RESET_SUB  = 1'b1
  } lif_mode_e;

endpackage

// File: rtl/lif_cfg_regs.sv
// Runtime configuration for one neuron node: threshold, refractory length and
// reset mode, plus a single-cycle pulse requesting that the saturation flag be cleared.
module lif_cfg_regs
  import lif_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int REFRAC_W   = 4,
  parameter int THRESH_RST = 32,
  parameter int REFRAC_RST = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cfg_we,
  input  logic [1:0]          cfg_addr,
  input  logic [WIDTH-1:0]    cfg_wdata,
  output logic [WIDTH-1:0]    o_thresh,
  output logic [REFRAC_W-1:0] o_refrac_len,
  output lif_mode_e           o_mode,
  output logic                o_clr_sat
);

  logic [WIDTH-1:0]    r_thresh;
  logic [REFRAC_W-1:0] r_refrac_len;
  lif_mode_e           r_mode;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_thresh     <= WIDTH'(THRESH_RST);
      r_refrac_len <= REFRAC_W'(REFRAC_RST);
      r_mode       <= RESET_ZERO;
    end else if (cfg_we) begin
      case (cfg_addr)
        CFG_THRESH: r_thresh     <= cfg_wdata;
        CFG_REFRAC: r_refrac_len <= cfg_wdata[REFRAC_W-1:0];
        CFG_MODE:   r_mode       <= lif_mode_e'(cfg_wdata[0]);
        default:    ;
      endcase
    end
  end

  assign o_thresh     = r_thresh;
  assign o_refrac_len = r_refrac_len;
  assign o_mode       = r_mode;
  assign o_clr_sat    = cfg_we && (cfg_addr == CFG_CLRSAT);

endmodule

// File: rtl/lif_node_param.sv
// Parametrised leaky integrate-and-fire node: leaky saturating integration,
// threshold compare on the freshly computed potential, and a refractory hold-off.
module lif_node_param
  import lif_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int LEAK_SHIFT = 1,
  parameter int REFRAC_W   = 4,
  parameter int THRESH_RST = 32,
  parameter int REFRAC_RST = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] current,
  input  logic             cfg_we,
  input  logic [1:0]       cfg_addr,
  input  logic [WIDTH-1:0] cfg_wdata,
  output logic [WIDTH-1:0] state_o,
  output logic             spike,
  output logic             refrac,
  output logic             sat
);

  logic [WIDTH-1:0]    w_thresh;
  logic [REFRAC_W-1:0] w_refrac_len;
  lif_mode_e           w_mode;
  logic                w_clr_sat;

  logic [WIDTH-1:0]    r_state;
  logic [REFRAC_W-1:0] r_cnt;
  logic                r_spike;
  logic                r_sat;

  logic [WIDTH:0]      w_sum;
  logic                w_ovf;
  logic [WIDTH-1:0]    w_nxt;
  logic                w_fire;
  logic                w_integrate;

  lif_cfg_regs #(
    .WIDTH      (WIDTH),
    .REFRAC_W   (REFRAC_W),
    .THRESH_RST (THRESH_RST),
    .REFRAC_RST (REFRAC_RST)
  ) u_cfg (
    .clk          (clk),
    .rst_n        (rst_n),
    .cfg_we       (cfg_we),
    .cfg_addr     (cfg_addr),
    .cfg_wdata    (cfg_wdata),
    .o_thresh     (w_thresh),
    .o_refrac_len (w_refrac_len),
    .o_mode       (w_mode),
    .o_clr_sat    (w_clr_sat)
  );

  // One extra bit catches the carry that drives saturation.
  assign w_sum       = (WIDTH+1)'(current) + (WIDTH+1)'(r_state >> LEAK_SHIFT);
  assign w_ovf       = w_sum[WIDTH];
  assign w_nxt       = w_ovf ? '1 : w_sum[WIDTH-1:0];
  assign w_fire      = (w_nxt >= w_thresh);
  assign w_integrate = en && (r_cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= '0;
      r_cnt   <= '0;
      r_spike <= 1'b0;
    end else begin
      r_spike <= 1'b0;
      if (en) begin
        if (r_cnt != '0) begin
          r_state <= '0;
          r_cnt   <= r_cnt - 1'b1;
        end else if (w_fire) begin
          r_spike <= 1'b1;
          r_cnt   <= w_refrac_len;
          // nxt >= thresh here, so the subtraction cannot wrap.
          r_state <= (w_mode == RESET_SUB) ? (w_nxt - w_thresh) : '0;
        end else begin
          r_state <= w_nxt;
        end
      end
    end
  end

  // A saturation in the same cycle as a clear request keeps the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sat <= 1'b0;
    end else if (w_integrate && w_ovf) begin
      r_sat <= 1'b1;
    end else if (w_clr_sat) begin
      r_sat <= 1'b0;
    end
  end

  assign state_o = r_state;
  assign spike   = r_spike;
  assign refrac  = (r_cnt != '0);
  assign sat     = r_sat;

endmodule

// File: tb/tb_lif_node_param.sv
// Directed bench for lif_node_param with hand-computed expectations for each
// timestep, config write and reset scenario.
module tb_lif_node_param;
  import lif_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [7:0] current;
  logic       cfg_we;
  logic [1:0] cfg_addr;
  logic [7:0] cfg_wdata;
  logic [7:0] state_o;
  logic       spike;
  logic       refrac;
  logic       sat;

  int errors = 0;
  int checks = 0;

  lif_node_param #(
    .WIDTH      (8),
    .LEAK_SHIFT (1),
    .REFRAC_W   (4),
    .THRESH_RST (32),
    .REFRAC_RST (0)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .current   (current),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_wdata (cfg_wdata),
    .state_o   (state_o),
    .spike     (spike),
    .refrac    (refrac),
    .sat       (sat)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    rst_n     = 1'b0;
    en        = 1'b0;
    current   = '0;
    cfg_we    = 1'b0;
    cfg_addr  = '0;
    cfg_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Checker
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drivers: each returns 1 time unit after the active edge.
  task automatic step(input logic [7:0] cur);
    en      = 1'b1;
    current = cur;
    @(posedge clk);
    #1;
    en = 1'b0;
  endtask

  task automatic idle();
    en = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [1:0] addr, input logic [7:0] data);
    cfg_we    = 1'b1;
    cfg_addr  = addr;
    cfg_wdata = data;
    @(posedge clk);
    #1;
    cfg_we = 1'b0;
  endtask

  task automatic step_cfg(input logic [7:0] cur, input logic [1:0] addr, input logic [7:0] data);
    en        = 1'b1;
    current   = cur;
    cfg_we    = 1'b1;
    cfg_addr  = addr;
    cfg_wdata = data;
    @(posedge clk);
    #1;
    en     = 1'b0;
    cfg_we = 1'b0;
  endtask

  initial begin
    logic [7:0] exp1_state[6];
    logic [7:0] exp2_state[6];
    logic       exp2_spike[6];
    logic [7:0] exp3_state[6];
    logic       exp4_spike[4];
    logic       exp4_refrac[4];

    exp1_state  = '{8'd10, 8'd15, 8'd17, 8'd18, 8'd19, 8'd19};
    exp2_state  = '{8'd20, 8'd30, 8'd0, 8'd20, 8'd30, 8'd0};
    exp2_spike  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    exp3_state  = '{8'd20, 8'd30, 8'd3, 8'd21, 8'd30, 8'd3};
    exp4_spike  = '{1'b1, 1'b0, 1'b0, 1'b1};
    exp4_refrac = '{1'b1, 1'b1, 1'b0, 1'b1};

    // 1: reset state, then sub-threshold leaky integration of 10
    do_reset();
    chk("rst_state", state_o, 0);
    chk("rst_spike", spike, 0);
    chk("rst_refrac", refrac, 0);
    chk("rst_sat", sat, 0);
    for (int i = 0; i < 6; i++) begin
      step(8'd10);
      chk($sformatf("s1_state%0d", i), state_o, exp1_state[i]);
      chk($sformatf("s1_spike%0d", i), spike, 0);
    end
    chk("s1_sat", sat, 0);

    // 2: mode 0, current 20 fires every third step
    do_reset();
    for (int i = 0; i < 6; i++) begin
      step(8'd20);
      chk($sformatf("s2_state%0d", i), state_o, exp2_state[i]);
      chk($sformatf("s2_spike%0d", i), spike, exp2_spike[i]);
    end

    // 3: mode 1 subtracts the threshold on firing
    do_reset();
    cfg_write(CFG_MODE, 8'd1);
    for (int i = 0; i < 6; i++) begin
      step(8'd20);
      chk($sformatf("s3_state%0d", i), state_o, exp3_state[i]);
      chk($sformatf("s3_spike%0d", i), spike, exp2_spike[i]);
    end

    // 4: refractory length 2
    do_reset();
    cfg_write(CFG_REFRAC, 8'd2);
    for (int i = 0; i < 4; i++) begin
      step(8'd40);
      chk($sformatf("s4_state%0d", i), state_o, 0);
      chk($sformatf("s4_spike%0d", i), spike, exp4_spike[i]);
      chk($sformatf("s4_refrac%0d", i), refrac, exp4_refrac[i]);
    end

    // 5: saturation, clear, and clear colliding with saturation
    do_reset();
    cfg_write(CFG_THRESH, 8'd255);
    step(8'd200);
    chk("s5_state_a", state_o, 200);
    chk("s5_sat_a", sat, 0);
    chk("s5_spike_a", spike, 0);
    step(8'd200);
    chk("s5_state_b", state_o, 0);
    chk("s5_sat_b", sat, 1);
    chk("s5_spike_b", spike, 1);
    cfg_write(CFG_CLRSAT, 8'd0);
    chk("s5_clr", sat, 0);
    step(8'd200);
    chk("s5_state_c", state_o, 200);
    step_cfg(8'd200, CFG_CLRSAT, 8'd0);
    chk("s5_sat_collide", sat, 1);
    chk("s5_spike_c", spike, 1);

    // 6a: en=0 holds state and drops spike
    do_reset();
    step(8'd20);
    step(8'd20);
    for (int i = 0; i < 5; i++) begin
      idle();
      chk($sformatf("s6a_hold%0d", i), state_o, 30);
      chk($sformatf("s6a_spike%0d", i), spike, 0);
    end
    step(8'd20);
    chk("s6a_fire", spike, 1);
    idle();
    chk("s6a_drop", spike, 0);

    // 6b: threshold write during a crossing step uses the old threshold
    do_reset();
    step(8'd20);
    step(8'd20);
    step_cfg(8'd20, CFG_THRESH, 8'd100);
    chk("s6b_old_fire", spike, 1);
    chk("s6b_old_state", state_o, 0);
    step(8'd20);
    step(8'd20);
    step(8'd20);
    step(8'd20);
    chk("s6b_new_state", state_o, 37);
    chk("s6b_new_spike", spike, 0);

    // 6c: asynchronous reset between edges, config back to defaults
    do_reset();
    cfg_write(CFG_THRESH, 8'd255);
    cfg_write(CFG_MODE, 8'd1);
    cfg_write(CFG_REFRAC, 8'd3);
    step(8'd200);
    step(8'd200);
    chk("s6c_pre_spike", spike, 1);
    chk("s6c_pre_refrac", refrac, 1);
    chk("s6c_pre_sat", sat, 1);
    rst_n = 1'b0;
    #2;
    chk("s6c_rst_spike", spike, 0);
    chk("s6c_rst_refrac", refrac, 0);
    chk("s6c_rst_sat", sat, 0);
    chk("s6c_rst_state", state_o, 0);
    rst_n = 1'b1;
    step(8'd20);
    chk("s6c_def_a", state_o, 20);
    rst_n = 1'b0;
    #2;
    chk("s6c_rst_state2", state_o, 0);
    rst_n = 1'b1;
    step(8'd20);
    step(8'd20);
    step(8'd20);
    chk("s6c_def_thresh", spike, 1);
    chk("s6c_def_mode", state_o, 0);
    chk("s6c_def_refrac", refrac, 0);
    step(8'd20);
    chk("s6c_def_next", state_o, 20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
